// File: rtl/alu_shift_pkg.sv
// Shared op and FSM state encodings for the iterative shifter and the ALU decoder.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_shift_stage.sv
// One log-shifter stage: shifts/rotates by 2^stage_i when en_i is set, else passes through.
// Purely combinational; SRA fill comes from val_i's MSB, which arithmetic stages preserve.
module alu_shift_stage
  import alu_shift_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic [XLEN-1:0]    val_i,
  input  op_e                op_i,
  input  logic [SHAMT_W-1:0] stage_i,
  input  logic               en_i,
  output logic [XLEN-1:0]    val_o
);

  logic [SHAMT_W-1:0] amt;
  logic [SHAMT_W:0]   rot_r;

  assign amt   = SHAMT_W'(1) << stage_i;
  assign rot_r = (SHAMT_W+1)'(XLEN) - (SHAMT_W+1)'(amt);

  always_comb begin
    val_o = val_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  val_o = val_i << amt;
        OP_SRL:  val_o = val_i >> amt;
        OP_SRA:  val_o = $unsigned($signed(val_i) >>> amt);
        OP_ROL:  val_o = (val_i << amt) | (val_i >> rot_r);
        default: val_o = val_i;
      endcase
    end
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Iterative shifter: one log stage per cycle, SHAMT_W cycles (1 when shamt==0), single request in flight.
// in_ready only in IDLE; result held in DONE until out_ready; flush aborts from any state.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd
);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  op_e                op_q, op_d;
  logic [XLEN-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]    stage_val;
  logic               unused_rs2_hi;

  assign unused_rs2_hi = ^rs2[XLEN-1:SHAMT_W];

  // rd_q doubles as the working register between stages.
  alu_shift_stage #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .val_i   (rd_q),
    .op_i    (op_q),
    .stage_i (cnt_q),
    .en_i    (shamt_q[cnt_q]),
    .val_o   (stage_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d    = op_e'(op);
            shamt_d = rs2[SHAMT_W-1:0];
            rd_d    = rs1;
            cnt_d   = '0;
            state_d = (rs2[SHAMT_W-1:0] == '0) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          rd_d  = stage_val;
          cnt_d = cnt_q + SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(SHAMT_W - 1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shamt_q <= '0;
      op_q    <= OP_SLL;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign rd        = rd_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: directed vector table, random ops against a reference model,
// and hand-written hold / reset / flush sequences.
module tb_alu_shift_seq;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  alu_shift_seq #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: shift amount is rs2 mod 32; rotate via a doubled word.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                            input int unsigned s);
    logic [63:0] d;
    case (o)
      2'd0:    return a << s;
      2'd1:    return a >> s;
      2'd2:    return 32'($signed(a) >>> s);
      default: begin
        d = {a, a} << s;
        return d[63:32];
      end
    endcase
  endfunction

  function automatic int exp_edges(input logic [31:0] b);
    return (b[4:0] == 5'd0) ? 0 : SHAMT_W;
  endfunction

  // Edges counted after the acceptance edge until out_valid is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int edges);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
    res = rd;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_pop", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] a, b, e;
    logic [1:0]  o;
    int          edges;
    bit          saw_valid;

    vecs[0]  = '{2'd0, 32'h0000_0001, 32'd1,  32'h0000_0002};
    vecs[1]  = '{2'd0, 32'hFFFF_FFFF, 32'd3,  32'hFFFF_FFF8};
    vecs[2]  = '{2'd0, 32'h0000_0001, 32'd33, 32'h0000_0002};
    vecs[3]  = '{2'd2, 32'h8000_0000, 32'd4,  32'hF800_0000};
    vecs[4]  = '{2'd1, 32'h8000_0000, 32'd4,  32'h0800_0000};
    vecs[5]  = '{2'd3, 32'h8000_0001, 32'd1,  32'h0000_0003};
    vecs[6]  = '{2'd0, 32'h1234_5678, 32'd0,  32'h1234_5678};
    vecs[7]  = '{2'd2, 32'h7FFF_FFFF, 32'd31, 32'h0000_0000};
    vecs[8]  = '{2'd3, 32'h1234_5678, 32'd16, 32'h5678_1234};
    vecs[9]  = '{2'd1, 32'hFFFF_FFFF, 32'd31, 32'h0000_0001};
    vecs[10] = '{2'd0, 32'h0000_0001, 32'd31, 32'h8000_0000};
    vecs[11] = '{2'd2, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'd0; rs1 = '0; rs2 = '0;
    #2;
    chk("reset_state", {in_ready, out_valid, rd}, {1'b1, 1'b0, 32'h0});
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, res, edges);
      chk($sformatf("vec%0d_rd", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), edges, exp_edges(vecs[i].b));
      pop();
    end

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 7 == 0) b[4:0] = 5'd0;
      run_op(o, a, b, res, edges);
      chk($sformatf("rand%0d_rd", i), res, ref_shift(o, a, b[4:0]));
      chk($sformatf("rand%0d_latency", i), edges, exp_edges(b));
      pop();
    end

    // Result held in DONE under backpressure; new requests ignored.
    run_op(2'd0, 32'h0000_00F0, 32'd2, res, edges);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; op = 2'd1; rs1 = 32'hDEAD_BEEF; rs2 = 32'd0;
      @(posedge clk); #1;
      chk($sformatf("hold%0d", c), {out_valid, in_ready, rd}, {1'b1, 1'b0, 32'h0000_03C0});
    end
    in_valid = 1'b0;
    pop();
    chk("hold_rd_after_pop", rd, 32'h0000_03C0);

    // Asynchronous reset in the middle of a BUSY cycle.
    op = 2'd1; rs1 = 32'hFFFF_0000; rs2 = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midbusy_reset", {in_ready, out_valid, rd}, {1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(2'd3, 32'hF000_000F, 32'd4, res, edges);
    chk("post_reset_rd", res, 32'h0000_00FF);
    chk("post_reset_latency", edges, SHAMT_W);
    pop();

    // Flush after one BUSY stage: only bit 0 of shamt has been applied.
    a = 32'h8000_0000; b = 32'h1F;
    op = 2'd2; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    e = ref_shift(2'd2, a, b[0]);
    chk("flush_busy_state", {in_ready, out_valid}, 2'b10);
    chk("flush_busy_rd_held", rd, e);
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("flush_no_out_valid", saw_valid, 1'b0);

    // Flush beats acceptance in IDLE.
    in_valid = 1'b1; flush = 1'b1; op = 2'd0; rs1 = 32'h5555_5555; rs2 = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept", {in_ready, out_valid, rd}, {1'b1, 1'b0, e});

    // Flush discards a completed result.
    run_op(2'd1, 32'h0000_0100, 32'd8, res, edges);
    chk("flush_done_pre_rd", res, 32'h0000_0001);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_state", {in_ready, out_valid, rd}, {1'b1, 1'b0, 32'h0000_0001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
